fpu_addsub: RTL

//  Parametrised IEEE-754-style floating-point add/subtract unit, next generation of the fpu core.

---
 rtl/fpu_addsub.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_addsub.sv
// fpu_addsub: multi-cycle IEEE-754-style add/subtract with ready/ack handshakes on both sides.
// Optional FPU_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fpu_addsub #(
   parameter  int EXP_WIDTH  = 8,
   parameter  int MANT_WIDTH = 23,
   localparam int BITNESS    = 1 + EXP_WIDTH + MANT_WIDTH
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               input_rdy,
   output logic               input_ack,
   output logic               output_rdy,
   input  logic               output_ack,
   input  logic [BITNESS-1:0] data_a,
   input  logic [BITNESS-1:0] data_b,
   input  logic [3:0]         command,
   output logic [BITNESS-1:0] result,
   output logic [3:0]         status
);
   localparam int EW = EXP_WIDTH;
   localparam int MW = MANT_WIDTH;
   localparam int XW = EW + 2;
   localparam int WM = MW + 4;
   localparam int SW = MW + 5;
   localparam int CW = $clog2(MW + 4) + 1;

`ifdef FPU_ROUND_NEAREST_EN
   localparam bit RNE_EN = 1'b1;
`else
   localparam bit RNE_EN = 1'b0;
`endif

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_UNPACK  = 3'd1;
   localparam logic [2:0] S_SPECIAL = 3'd2;
   localparam logic [2:0] S_ALIGN   = 3'd3;
   localparam logic [2:0] S_ADD     = 3'd4;
   localparam logic [2:0] S_NORM    = 3'd5;
   localparam logic [2:0] S_ROUND   = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0001;

   localparam logic signed [XW-1:0] ONE     = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);
   localparam logic [BITNESS-1:0]   QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   function automatic logic [WM-1:0] shr_sticky(input logic [WM-1:0] m);
      return {1'b0, m[WM-1:2], m[1] | m[0]};
   endfunction

   function automatic logic round_up(input logic g, input logic r, input logic s, input logic lsb);
      return RNE_EN ? (g & (r | s | lsb)) : 1'b0;
   endfunction

   // Truncation saturates to the largest finite magnitude instead of reaching Inf.
   function automatic logic [BITNESS-1:0] ovf_value(input logic sgn);
      return RNE_EN ? {sgn, {EW{1'b1}}, {MW{1'b0}}}
                    : {sgn, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
   endfunction

   logic [2:0]                state_q, state_d;
   logic                      in_ack_q, in_ack_d;
   logic                      out_rdy_q, out_rdy_d;
   logic [BITNESS-1:0]        result_q, result_d;
   logic [3:0]                status_q, status_d;

   logic [BITNESS-1:0]        a_q, a_d, b_q, b_d;
   logic [3:0]                cmd_q, cmd_d;
   logic                      sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
   logic signed [XW-1:0]      ea_q, ea_d, eb_q, eb_d, er_q, er_d;
   logic [WM-1:0]             ma_q, ma_d, mb_q, mb_d;
   logic [SW-1:0]             sum_q, sum_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      zero_a_q, zero_a_d, zero_b_q, zero_b_d;
   logic                      inf_a_q, inf_a_d, inf_b_q, inf_b_d;
   logic                      nan_a_q, nan_a_d, nan_b_q, nan_b_d;

   logic [MW:0]               frac_rnd;
   logic signed [XW-1:0]      exp_rnd;
   logic                      inexact;

   always_comb begin
      state_d   = state_q;
      in_ack_d  = 1'b0;
      out_rdy_d = out_rdy_q;
      result_d  = result_q;
      status_d  = status_q;
      a_d = a_q;   b_d = b_q;   cmd_d = cmd_q;
      sa_d = sa_q; sb_d = sb_q; sr_d = sr_q;
      ea_d = ea_q; eb_d = eb_q; er_d = er_q;
      ma_d = ma_q; mb_d = mb_q; sum_d = sum_q; cnt_d = cnt_q;
      zero_a_d = zero_a_q; zero_b_d = zero_b_q;
      inf_a_d  = inf_a_q;  inf_b_d  = inf_b_q;
      nan_a_d  = nan_a_q;  nan_b_d  = nan_b_q;
      frac_rnd = '0;
      exp_rnd  = '0;
      inexact  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (input_rdy) begin
               a_d      = data_a;
               b_d      = data_b;
               cmd_d    = command;
               in_ack_d = 1'b1;
               state_d  = S_UNPACK;
            end
         end
         S_UNPACK: begin
            sa_d     = a_q[BITNESS-1];
            sb_d     = b_q[BITNESS-1] ^ (cmd_q == CMD_SUB);
            ea_d     = signed'({2'b00, a_q[BITNESS-2:MW]});
            eb_d     = signed'({2'b00, b_q[BITNESS-2:MW]});
            zero_a_d = (a_q[BITNESS-2:MW] == '0);
            zero_b_d = (b_q[BITNESS-2:MW] == '0);
            inf_a_d  = (a_q[BITNESS-2:MW] == '1) && (a_q[MW-1:0] == '0);
            inf_b_d  = (b_q[BITNESS-2:MW] == '1) && (b_q[MW-1:0] == '0);
            nan_a_d  = (a_q[BITNESS-2:MW] == '1) && (a_q[MW-1:0] != '0);
            nan_b_d  = (b_q[BITNESS-2:MW] == '1) && (b_q[MW-1:0] != '0);
            ma_d     = {1'b1, a_q[MW-1:0], 3'b000};
            mb_d     = {1'b1, b_q[MW-1:0], 3'b000};
            state_d  = S_SPECIAL;
         end
         S_SPECIAL: begin
            state_d   = S_DONE;
            out_rdy_d = 1'b1;
            status_d  = 4'b0000;
            if ((cmd_q != CMD_ADD && cmd_q != CMD_SUB) || nan_a_q || nan_b_q ||
                (inf_a_q && inf_b_q && (sa_q != sb_q))) begin
               result_d = QNAN;
               status_d = 4'b1000;
            end else if (inf_a_q) begin
               result_d = {sa_q, {EW{1'b1}}, {MW{1'b0}}};
            end else if (inf_b_q) begin
               result_d = {sb_q, {EW{1'b1}}, {MW{1'b0}}};
            end else if (zero_a_q && zero_b_q) begin
               result_d = {sa_q & sb_q, {(BITNESS-1){1'b0}}};
            end else if (zero_a_q) begin
               result_d = {sb_q, b_q[BITNESS-2:0]};
            end else if (zero_b_q) begin
               result_d = a_q;
            end else begin
               state_d   = S_ALIGN;
               out_rdy_d = 1'b0;
               result_d  = result_q;
               status_d  = status_q;
               cnt_d     = '0;
            end
         end
         S_ALIGN: begin
            // Once the small operand has been shifted fully into S its exponent no longer matters.
            if (ea_q == eb_q || cnt_q == CW'(MW + 3)) begin
               er_d    = (ea_q > eb_q) ? ea_q : eb_q;
               state_d = S_ADD;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (ea_q < eb_q) begin
                  ma_d = shr_sticky(ma_q);
                  ea_d = ea_q + ONE;
               end else begin
                  mb_d = shr_sticky(mb_q);
                  eb_d = eb_q + ONE;
               end
            end
         end
         S_ADD: begin
            state_d = S_NORM;
            if (sa_q == sb_q) begin
               sum_d = {1'b0, ma_q} + {1'b0, mb_q};
               sr_d  = sa_q;
            end else if (ma_q == mb_q) begin
               result_d  = '0;
               status_d  = 4'b0000;
               out_rdy_d = 1'b1;
               state_d   = S_DONE;
            end else if (ma_q > mb_q) begin
               sum_d = {1'b0, ma_q - mb_q};
               sr_d  = sa_q;
            end else begin
               sum_d = {1'b0, mb_q - ma_q};
               sr_d  = sb_q;
            end
         end
         S_NORM: begin
            if (sum_q[SW-1]) begin
               sum_d   = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
               er_d    = er_q + ONE;
               state_d = S_ROUND;
            end else if (sum_q[SW-2]) begin
               state_d = S_ROUND;
            end else if (er_q <= ONE) begin
               result_d  = {sr_q, {(BITNESS-1){1'b0}}};
               status_d  = 4'b0011;
               out_rdy_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               sum_d = {sum_q[SW-2:0], 1'b0};
               er_d  = er_q - ONE;
            end
         end
         S_ROUND: begin
            // A carry out of the fraction leaves it all-zero, so only the exponent needs bumping.
            inexact  = |sum_q[2:0];
            frac_rnd = {1'b0, sum_q[SW-3:3]}
                       + (MW+1)'(round_up(sum_q[2], sum_q[1], sum_q[0], sum_q[3]));
            exp_rnd  = frac_rnd[MW] ? (er_q + ONE) : er_q;
            if (exp_rnd >= EXP_MAX) begin
               result_d = ovf_value(sr_q);
               status_d = 4'b0101;
            end else begin
               result_d = {sr_q, exp_rnd[EW-1:0], frac_rnd[MW-1:0]};
               status_d = {3'b000, inexact};
            end
            out_rdy_d = 1'b1;
            state_d   = S_DONE;
         end
         S_DONE: begin
            if (out_rdy_q && output_ack) begin
               out_rdy_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         in_ack_q  <= 1'b0;
         out_rdy_q <= 1'b0;
         result_q  <= '0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         in_ack_q  <= in_ack_d;
         out_rdy_q <= out_rdy_d;
         result_q  <= result_d;
         status_q  <= status_d;
      end
   end

   always_ff @(posedge clock) begin
      a_q <= a_d;   b_q <= b_d;   cmd_q <= cmd_d;
      sa_q <= sa_d; sb_q <= sb_d; sr_q <= sr_d;
      ea_q <= ea_d; eb_q <= eb_d; er_q <= er_d;
      ma_q <= ma_d; mb_q <= mb_d; sum_q <= sum_d; cnt_q <= cnt_d;
      zero_a_q <= zero_a_d; zero_b_q <= zero_b_d;
      inf_a_q  <= inf_a_d;  inf_b_q  <= inf_b_d;
      nan_a_q  <= nan_a_d;  nan_b_q  <= nan_b_d;
   end

   assign input_ack  = in_ack_q;
   assign output_rdy = out_rdy_q;
   assign result     = result_q;
   assign status     = status_q;

endmodule
